mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit for the pipeline CPU's MEM stage: the initiator that drives the data memory's write/read port. It accepts one load or store at a time from EX over a valid/ready handshake. It sequences the memory's one-cycle registered read, performs byte read-modify-write, and returns a single-cycle response pulse to WB.

## Interface
- ADDR_W, 7, word-address width of the data memory (128 words)
- DATA_W, 16, memory word width; byte lanes are [7:0] (lane 0) and [15:8] (lane 1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  2  00 LW, 01 SW, 10 LB, 11 SB
- req_addr  in  ADDR_W+1  byte address; [ADDR_W:1] word, [0] lane
- req_wdata  in  DATA_W  store data; SB uses [7:0] only
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  DATA_W  load data; 0 for stores; LB zero-extended
- mem_we  out  1  memory write enable
- mem_w_addr  out  ADDR_W  memory write address
- mem_r_addr  out  ADDR_W  memory read address
- mem_data_in  out  DATA_W  memory write data
- mem_data_out  in  DATA_W  memory read data, registered one edge after mem_r_addr

## Operation
- **Handshake:** a request is accepted on any edge where req_valid && req_ready. The unit latches op, word address, lane and wdata into internal registers.
- **Memory port drive:**
  - mem_w_addr and mem_r_addr are both driven from the latched word address in every state.
  - mem_data_in is driven from the latched/merged data register.
  - mem_we is combinational from state.
- **FSM states:** IDLE, ACCESS, CAPTURE, MODIFY.
  - **IDLE:** req_ready=1, mem_we=0. On accept → ACCESS.
  - **ACCESS:** mem_we=1 iff op=SW, with mem_data_in=wdata.
    - SW → IDLE and register resp_valid.
    - LW, LB, SB → CAPTURE.
  - **CAPTURE:** mem_data_out holds the addressed word.
    - LW: register resp_rdata=mem_data_out, then → IDLE.
    - LB: register resp_rdata={8'h00, selected lane}, then → IDLE.
    - SB: load the data register with mem_data_out, replacing the selected lane with wdata[7:0], then → MODIFY.
  - **MODIFY:** mem_we=1, mem_data_in=merged word, then → IDLE and register resp_valid.
- **Response:** resp_valid and resp_rdata are registered. resp_valid is high for exactly one cycle and has no backpressure. resp_rdata holds its value until the next response.
- **Ordering:** the unit is strictly serial, so there are no address hazards. A load after a store to the same word always returns the stored data.
- **Unwritten memory:** memory words read 16'h00FF after power-up, so LW of an unwritten word returns 16'h00FF.

## Timing
Accept edge is E0.
- **SW:** the write occurs at E1. resp_valid is high in the cycle after E1 (2-cycle latency).
- **LW/LB:** the memory samples the address at E1, CAPTURE registers the response at E2, and resp_valid is high after E2 (3-cycle latency).
- **SB:** the read is sampled at E1, the merge happens at E2, the write occurs at E3, and resp_valid is high after E3 (4-cycle latency).
- **Back-to-back:** IDLE coincides with the resp_valid cycle, so a new request can be accepted in that same cycle. Throughput is therefore 1 op per 2/3/4 cycles.
- **Reset values:**
  - State IDLE; req_ready=1 in the first cycle after reset.
  - resp_valid=0, resp_rdata=0, mem_we=0.
  - Latched address=0, data register=0.
- **Reset mid-operation:** the in-flight op is aborted and no resp_valid is produced. A write already on the port in the reset cycle (ACCESS for SW, MODIFY for SB) lands in memory, because the memory does not gate writes on rst. An SB reset in ACCESS or CAPTURE writes nothing.
- req_valid is ignored while not IDLE; the requester holds it.

## Configuration
- **MEM_LSU_BYTE_OPS_EN defined:** LB/SB behave as described above, and the MODIFY state and lane-merge logic are present.
- **Not defined:**
  - op 10 behaves exactly as LW and op 11 exactly as SW.
  - req_addr[0] is ignored.
  - MODIFY and the merge logic are not built.
  - Latencies are 3 cycles for loads and 2 cycles for stores.

## Structure
- **Shared package cpu_pkg:**
  - op encodings OP_LW/OP_SW/OP_LB/OP_SB.
  - mem_lsu FSM state encoding.
  - the MEM_INIT_WORD=16'h00FF constant, shared with the memory model.
- **Sub-module mem_lsu_lane:** combinational lane extract (zero-extend) and lane merge. It is instantiated only under MEM_LSU_BYTE_OPS_EN.
- **Bench:** the team's 128×16 data memory is instantiated alongside the unit.

## Test plan
- **Reset:** rst held 2 cycles then released → req_ready=1, resp_valid=0, mem_we=0, resp_rdata=0.
- **Unwritten load:** LW addr 0x10 on a fresh memory → resp_valid 3 cycles after accept, resp_rdata=16'h00FF.
- **Store then load:** SW 0x20←16'hBEEF, then LW 0x20 accepted in the resp cycle → resp_rdata=16'hBEEF; mem_we high exactly 1 cycle in total.
- **Byte store/load:** word 0x21=16'h1234; SB byte addr 0x43 (word 0x21, lane 1) data 8'hAB → memory word becomes 16'hAB34. LB 0x42 → 16'h0034; LB 0x43 → 16'h00AB.
- **Byte ops disabled (macro undefined):** SB 0x43 with wdata 16'h5678 → memory word 0x21=16'h5678, resp after 2 cycles.
- **Reset mid-SB:** rst asserted in CAPTURE → no resp_valid; memory word unchanged; next LW returns the old value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: LSU op encodings, LSU FSM state encoding and memory init word.
// Byte operations in mem_lsu are enabled by defining MEM_LSU_BYTE_OPS_EN.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_LW = 2'b00,
    OP_SW = 2'b01,
    OP_LB = 2'b10,
    OP_SB = 2'b11
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACCESS  = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_MODIFY  = 2'b11
  } lsu_state_e;

  // Power-up content of every data memory word.
  localparam logic [15:0] MEM_INIT_WORD = 16'h00FF;

  localparam int LSU_LANE_W = 8;

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte lane helper for mem_lsu: zero-extended lane extract and lane merge.
// Only built when MEM_LSU_BYTE_OPS_EN is defined.
`ifdef MEM_LSU_BYTE_OPS_EN
module mem_lsu_lane
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]     word_i,
  input  logic                  lane_i,
  input  logic [LSU_LANE_W-1:0] byte_i,
  output logic [DATA_W-1:0]     extract_o,
  output logic [DATA_W-1:0]     merged_o
);

  logic [LSU_LANE_W-1:0] laneLow;
  logic [LSU_LANE_W-1:0] laneHigh;

  assign laneLow  = word_i[LSU_LANE_W-1:0];
  assign laneHigh = word_i[DATA_W-1:LSU_LANE_W];

  assign extract_o = {{(DATA_W-LSU_LANE_W){1'b0}}, (lane_i ? laneHigh : laneLow)};

  // The unselected lane is carried through untouched from the word just read.
  assign merged_o = lane_i ? {byte_i, laneLow} : {laneHigh, byte_i};

endmodule
`endif

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit driving a one-cycle registered-read data memory.
// Define MEM_LSU_BYTE_OPS_EN to build LB/SB support (MODIFY state and lane merge).
module mem_lsu
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  lsu_state_e        state_q;
  lsu_op_e           op_q;
  lsu_op_e           reqOp;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;

`ifdef MEM_LSU_BYTE_OPS_EN
  logic              lane_q;
  logic [DATA_W-1:0] laneExtract;
  logic [DATA_W-1:0] laneMerged;

  assign reqOp = lsu_op_e'(req_op);

  mem_lsu_lane #(
    .DATA_W (DATA_W)
  ) u_lane (
    .word_i    (mem_data_out),
    .lane_i    (lane_q),
    .byte_i    (data_q[LSU_LANE_W-1:0]),
    .extract_o (laneExtract),
    .merged_o  (laneMerged)
  );
`else
  logic [1:0] unused_byteBits;

  // Without byte support LB folds onto LW and SB onto SW; the lane bit is dropped.
  assign reqOp           = req_op[0] ? OP_SW : OP_LW;
  assign unused_byteBits = {req_op[1], req_addr[0]};
`endif

  assign req_ready   = (state_q == ST_IDLE);
  assign mem_we      = ((state_q == ST_ACCESS) && (op_q == OP_SW)) || (state_q == ST_MODIFY);
  assign mem_w_addr  = addr_q;
  assign mem_r_addr  = addr_q;
  assign mem_data_in = data_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;

  // Control FSM; a reset mid-operation simply drops the op and its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_LW;
      addr_q       <= '0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef MEM_LSU_BYTE_OPS_EN
      lane_q       <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= reqOp;
            addr_q  <= req_addr[ADDR_W:1];
            data_q  <= req_wdata;
`ifdef MEM_LSU_BYTE_OPS_EN
            lane_q  <= req_addr[0];
`endif
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (op_q == OP_SW) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          case (op_q)
`ifdef MEM_LSU_BYTE_OPS_EN
            OP_LB: begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= laneExtract;
              state_q      <= ST_IDLE;
            end
            OP_SB: begin
              data_q  <= laneMerged;
              state_q <= ST_MODIFY;
            end
`endif
            default: begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= mem_data_out;
              state_q      <= ST_IDLE;
            end
          endcase
        end
`ifdef MEM_LSU_BYTE_OPS_EN
        ST_MODIFY: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
          state_q      <= ST_IDLE;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu with a 128x16 registered-read data memory and a reference model.
// Follows MEM_LSU_BYTE_OPS_EN for the expected LB/SB behaviour.
module tb_mem_lsu;
  import cpu_pkg::*;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W:0]   req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  int nCompared;
  int nMismatched;

  mem_lsu #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_we       (mem_we),
    .mem_w_addr   (mem_w_addr),
    .mem_r_addr   (mem_r_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: write and registered read on the same edge, no reset.
  logic [DATA_W-1:0] memArray [128];
  initial begin
    for (int i = 0; i < 128; i++) memArray[i] = MEM_INIT_WORD;
  end
  always @(posedge clk) begin
    if (mem_we) memArray[mem_w_addr] <= mem_data_in;
    mem_data_out <= memArray[mem_r_addr];
  end

  // Reference memory contents as seen by a serial stream of ops.
  int refMem [128];
  initial begin
    for (int i = 0; i < 128; i++) refMem[i] = int'(MEM_INIT_WORD);
  end

  function automatic bit byteOpsEnabled();
`ifdef MEM_LSU_BYTE_OPS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Architectural effect of one op: expected read data, latency and number of write cycles.
  task automatic refOp(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd,
                       output int rd, output int lat, output int we);
    int w;
    int sh;
    int effOp;
    w     = int'(addr[7:1]);
    sh    = byteOpsEnabled() ? 8 * int'(addr[0]) : 0;
    effOp = byteOpsEnabled() ? int'(op) : int'(op[0]);
    rd = 0; lat = 0; we = 0;
    case (effOp)
      0: begin rd = refMem[w]; lat = 3; end
      1: begin refMem[w] = int'(wd); lat = 2; we = 1; end
      2: begin rd = (refMem[w] >> sh) & 32'hFF; lat = 3; end
      default: begin
        refMem[w] = (refMem[w] & ~(32'hFF << sh)) | ((int'(wd) & 32'hFF) << sh);
        lat = 4;
        we  = 1;
      end
    endcase
  endtask

  // Issue one request from a negedge; returns at the negedge where resp_valid is seen.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd,
                               output int rd, output int lat, output int weCnt);
    int waitCnt;
    waitCnt = 0;
    rd = 0; lat = -1; weCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL readyTimeout: req_ready still 0 after %0d cycles", waitCnt);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = 1'b0;
      if (mem_we) weCnt++;
    end while (!resp_valid && lat < 10);
    if (!resp_valid) lat = -1;
    else rd = int'(resp_rdata);
  endtask

  task automatic checkOutput(input string name, input int rd, input int lat, input int we,
                             input int expRd, input int expLat, input int expWe);
    check({name, ".rdata"}, rd, expRd);
    check({name, ".latency"}, lat, expLat);
    check({name, ".weCycles"}, we, expWe);
  endtask

  // Reset during an op at the given negedge after accept (1 = ACCESS, 2 = CAPTURE).
  task automatic abortSequence(input string name, input logic [1:0] op, input logic [7:0] addr,
                               input logic [15:0] wd, input int rstAt);
    int respSeen;
    respSeen  = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= rstAt; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) respSeen++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({name, ".readyAfterRst"}, int'(req_ready), 1);
    check({name, ".rdataAfterRst"}, int'(resp_rdata), 0);
    for (int k = 0; k < 5; k++) begin
      if (resp_valid) respSeen++;
      @(negedge clk);
    end
    check({name, ".respPulses"}, respSeen, 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          expRdata;
    int          expLat;
    int          expWe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int rd, lat, we;
    int mRd, mLat, mWe;
    logic [1:0]  rOp;
    logic [7:0]  rAddr;
    logic [15:0] rData;

    nCompared   = 0;
    nMismatched = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;

    vecs[0] = '{OP_LW, 8'h20, 16'h0000, 32'h00FF, 3, 0};
    vecs[1] = '{OP_SW, 8'h40, 16'hBEEF, 32'h0000, 2, 1};
    vecs[2] = '{OP_LW, 8'h40, 16'h0000, 32'hBEEF, 3, 0};
    vecs[3] = '{OP_SW, 8'h42, 16'h1234, 32'h0000, 2, 1};
`ifdef MEM_LSU_BYTE_OPS_EN
    vecs[4] = '{OP_SB, 8'h43, 16'hCDAB, 32'h0000, 4, 1};
    vecs[5] = '{OP_LW, 8'h42, 16'h0000, 32'hAB34, 3, 0};
    vecs[6] = '{OP_LB, 8'h42, 16'h0000, 32'h0034, 3, 0};
    vecs[7] = '{OP_LB, 8'h43, 16'h0000, 32'h00AB, 3, 0};
`else
    vecs[4] = '{OP_SB, 8'h43, 16'h5678, 32'h0000, 2, 1};
    vecs[5] = '{OP_LW, 8'h42, 16'h0000, 32'h5678, 3, 0};
    vecs[6] = '{OP_LB, 8'h42, 16'h0000, 32'h5678, 3, 0};
    vecs[7] = '{OP_LB, 8'h43, 16'h0000, 32'h5678, 3, 0};
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.req_ready", int'(req_ready), 1);
    check("reset.resp_valid", int'(resp_valid), 0);
    check("reset.mem_we", int'(mem_we), 0);
    check("reset.resp_rdata", int'(resp_rdata), 0);
    check("reset.mem_w_addr", int'(mem_w_addr), 0);
    check("reset.mem_data_in", int'(mem_data_in), 0);

    // Directed table, issued back to back.
    for (int i = 0; i < 8; i++) begin
      refOp(vecs[i].op, vecs[i].addr, vecs[i].wdata, mRd, mLat, mWe);
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, lat, we);
      checkOutput($sformatf("vec%0d", i), rd, lat, we,
                  vecs[i].expRdata, vecs[i].expLat, vecs[i].expWe);
    end
    check("vec.memWord21", int'(memArray[7'h21]), byteOpsEnabled() ? 32'hAB34 : 32'h5678);
    @(negedge clk);
    check("vec.respPulseEnds", int'(resp_valid), 0);
    @(negedge clk);
    check("vec.rdataHeld", int'(resp_rdata), vecs[7].expRdata);

    // Reset while a store sits on the port: the write still lands.
    abortSequence("abortSW", OP_SW, 8'h60, 16'hC0DE, 1);
    refMem[7'h30] = 32'hC0DE;
    refOp(OP_LW, 8'h60, 16'h0, mRd, mLat, mWe);
    applyStimulus(OP_LW, 8'h60, 16'h0, rd, lat, we);
    checkOutput("abortSW.reload", rd, lat, we, 32'hC0DE, 3, 0);

    // Reset while a load waits for its data.
    abortSequence("abortLW", OP_LW, 8'h60, 16'h0, 2);

`ifdef MEM_LSU_BYTE_OPS_EN
    // Reset in CAPTURE of a byte store: the word keeps its old value.
    abortSequence("abortSB", OP_SB, 8'h61, 16'h0077, 2);
    refOp(OP_LW, 8'h60, 16'h0, mRd, mLat, mWe);
    applyStimulus(OP_LW, 8'h60, 16'h0, rd, lat, we);
    checkOutput("abortSB.reload", rd, lat, we, 32'hC0DE, 3, 0);
`endif

    // Random ops over a small window so loads frequently hit earlier stores.
    for (int i = 0; i < 80; i++) begin
      rOp   = 2'($urandom_range(0, 3));
      rAddr = 8'h80 + 8'($urandom_range(0, 15));
      rData = 16'($urandom);
      refOp(rOp, rAddr, rData, mRd, mLat, mWe);
      applyStimulus(rOp, rAddr, rData, rd, lat, we);
      checkOutput($sformatf("rand%0d", i), rd, lat, we, mRd, mLat, mWe);
    end

    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
